// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding and address/operand-index width helpers for multi_operand_controller
package ctrl_pkg;
  typedef enum logic [1:0] {S_INPUT, S_START, S_WAIT, S_DISPLAY} state_t;
  function automatic int addr_w(input int n, input int d);
    return (n * d > 1) ? $clog2(n * d) : 1;
  endfunction
  function automatic int op_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ctrl_addr_counter.sv
// ctrl_addr_counter: operand write pointer counting 0..N-1 with wrap and terminal-count flag
//   clk, rst : clock, async active-high reset
//   i_en     : advance pointer this cycle
//   o_ptr    : current pointer
//   o_tc     : pointer is at N-1 (the next advance wraps to 0)
module ctrl_addr_counter #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_ptr,
  output logic         o_tc
);
  logic [W-1:0] r_ptr;
  assign o_tc  = r_ptr == W'(N - 1);
  assign o_ptr = r_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_en) r_ptr <= o_tc ? '0 : r_ptr + 1'b1;
endmodule

// File: rtl/multi_operand_controller.sv
// multi_operand_controller: collects NUM_OPS x DEPTH operand words, starts compute, displays result
//   Optional macro CTRL_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on the compute wait.
//   Input stage  : input_value, input_value_ready -> input_enable, op_idx
//   Operand mem  : ctrl_mem_addr, ctrl_mem_wdata, ctrl_mem_wr, mode_compute
//   Compute      : comp_start -> comp_done, comp_result, comp_timeout
//   Display      : display_enable, display_value, restart
module multi_operand_controller
  import ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int NUM_OPS     = 2,
  parameter int TIMEOUT_CYC = 256,
  localparam int ADDR_W     = addr_w(NUM_OPS, DEPTH),
  localparam int OP_W       = op_w(NUM_OPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_value,
  input  logic              input_value_ready,
  output logic              input_enable,
  output logic [OP_W-1:0]   op_idx,
  output logic [ADDR_W-1:0] ctrl_mem_addr,
  output logic [DATA_W-1:0] ctrl_mem_wdata,
  output logic              ctrl_mem_wr,
  output logic              mode_compute,
  output logic              comp_start,
  input  logic              comp_done,
  input  logic [DATA_W-1:0] comp_result,
  output logic              comp_timeout,
  output logic              display_enable,
  output logic [DATA_W-1:0] display_value,
  input  logic              restart
);
  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_disp;
  logic [ADDR_W-1:0]   w_ptr;
  logic                w_tc, w_exp;
  ctrl_addr_counter #(.N(NUM_OPS * DEPTH), .W(ADDR_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (ctrl_mem_wr),
    .o_ptr (w_ptr),
    .o_tc  (w_tc)
  );
  // rst gates the combinational strobes so nothing is offered while reset is held
  assign input_enable   = r_state == S_INPUT && !rst;
  assign ctrl_mem_wr    = input_enable && input_value_ready;
  assign ctrl_mem_addr  = w_ptr;
  assign ctrl_mem_wdata = input_value;
  assign op_idx         = OP_W'(32'(w_ptr) / DEPTH);
  assign comp_start     = r_state == S_START;
  assign mode_compute   = r_state == S_START || r_state == S_WAIT;
  assign display_enable = r_state == S_DISPLAY;
  assign display_value  = r_disp;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INPUT:   w_next = (ctrl_mem_wr && w_tc) ? S_START : S_INPUT;
      S_START:   w_next = S_WAIT;
      S_WAIT:    w_next = (comp_done || w_exp) ? S_DISPLAY : S_WAIT;
      S_DISPLAY: w_next = restart ? S_INPUT : S_DISPLAY;
      default:   w_next = S_INPUT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_INPUT;
      r_disp  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && comp_done) r_disp <= comp_result;
      else if (w_exp || (r_state == S_DISPLAY && restart)) r_disp <= '0;
    end
`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;
  // counter is zero on entry to S_WAIT; comp_done in the expiry cycle takes priority
  assign w_exp        = r_state == S_WAIT && !comp_done && r_cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign comp_timeout = r_tmo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      if (w_exp) r_tmo <= 1'b1;
      else if (r_state == S_DISPLAY && restart) r_tmo <= 1'b0;
    end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYC;
  assign w_exp        = 1'b0;
  assign comp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_multi_operand_controller.sv
// tb_multi_operand_controller: directed tests for fill, compute handshake, ignores, reset and sizing
module tb_multi_operand_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] a_val = '0, a_wd, a_res = '0, a_dv;
  logic       a_rdy = 1'b0, a_ien, a_op, a_wr, a_mc, a_cs, a_done = 1'b0, a_tmo, a_de, a_rs = 1'b0;
  logic [3:0] a_addr;
  multi_operand_controller u_a (
    .clk(clk), .rst(rst), .input_value(a_val), .input_value_ready(a_rdy), .input_enable(a_ien),
    .op_idx(a_op), .ctrl_mem_addr(a_addr), .ctrl_mem_wdata(a_wd), .ctrl_mem_wr(a_wr),
    .mode_compute(a_mc), .comp_start(a_cs), .comp_done(a_done), .comp_result(a_res),
    .comp_timeout(a_tmo), .display_enable(a_de), .display_value(a_dv), .restart(a_rs)
  );
  logic [7:0] b_val = '0, b_wd, b_dv;
  logic       b_rdy = 1'b0, b_ien, b_wr, b_mc, b_cs, b_tmo, b_de;
  logic [1:0] b_op;
  logic [3:0] b_addr;
  multi_operand_controller #(.NUM_OPS(3), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .input_value(b_val), .input_value_ready(b_rdy), .input_enable(b_ien),
    .op_idx(b_op), .ctrl_mem_addr(b_addr), .ctrl_mem_wdata(b_wd), .ctrl_mem_wr(b_wr),
    .mode_compute(b_mc), .comp_start(b_cs), .comp_done(1'b0), .comp_result(8'h00),
    .comp_timeout(b_tmo), .display_enable(b_de), .display_value(b_dv), .restart(1'b0)
  );
`ifdef CTRL_TIMEOUT_EN
  logic [7:0] c_val = '0, c_wd, c_dv;
  logic       c_rdy = 1'b0, c_ien, c_op, c_addr, c_wr, c_mc, c_cs, c_tmo, c_de, c_rs = 1'b0;
  multi_operand_controller #(.NUM_OPS(1), .DEPTH(2), .TIMEOUT_CYC(32)) u_c (
    .clk(clk), .rst(rst), .input_value(c_val), .input_value_ready(c_rdy), .input_enable(c_ien),
    .op_idx(c_op), .ctrl_mem_addr(c_addr), .ctrl_mem_wdata(c_wd), .ctrl_mem_wr(c_wr),
    .mode_compute(c_mc), .comp_start(c_cs), .comp_done(1'b0), .comp_result(8'h00),
    .comp_timeout(c_tmo), .display_enable(c_de), .display_value(c_dv), .restart(c_rs)
  );
`endif
  task automatic a_write(input logic [7:0] v, input logic [3:0] addr);
    @(negedge clk);
    a_rdy = 1'b1;
    a_val = v;
    #1;
    checks++;
    if (a_wr !== 1'b1 || a_addr !== addr || a_wd !== v || a_op !== addr[3]) begin
      errors++;
      $display("FAIL a_write wr=%b addr=%0d data=%h op=%0d, want wr=1 addr=%0d data=%h op=%0d",
               a_wr, a_addr, a_wd, a_op, addr, v, addr[3]);
    end
  endtask
  task automatic a_fill;
    for (int i = 0; i < 16; i++) a_write(8'(i < 8 ? i + 1 : i + 3), 4'(i));
    @(negedge clk);
    a_rdy = 1'b0;
    #1;
    checks++;
    if (a_cs !== 1'b1 || a_mc !== 1'b1 || a_ien !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse cs=%b mc=%b ien=%b, want 1 1 0", a_cs, a_mc, a_ien);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_cs !== 1'b0 || a_mc !== 1'b1) begin
      errors++;
      $display("FAIL start_width cs=%b mc=%b, want 0 1", a_cs, a_mc);
    end
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if (a_ien !== 0 || a_wr !== 0 || a_cs !== 0 || a_mc !== 0 || a_de !== 0 || a_dv !== 0 || a_addr !== 0 || a_tmo !== 0) begin
      errors++;
      $display("FAIL reset_state ien=%b wr=%b cs=%b mc=%b de=%b dv=%h addr=%0d tmo=%b, want all 0",
               a_ien, a_wr, a_cs, a_mc, a_de, a_dv, a_addr, a_tmo);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_ien !== 1'b1 || b_ien !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ien=%b/%b, want 1/1", a_ien, b_ien);
    end
  endtask
  task automatic test_result;
    @(negedge clk);
    a_rdy = 1'b1;
    a_val = 8'h77;
    #1;
    checks++;
    if (a_wr !== 1'b0 || a_de !== 1'b0) begin
      errors++;
      $display("FAIL wait_ignore wr=%b de=%b, want 0 0", a_wr, a_de);
    end
    a_rdy = 1'b0;
    repeat (2) @(negedge clk);
    a_done = 1'b1;
    a_res  = 8'hFF;
    #1;
    checks++;
    if (a_de !== 1'b0 || a_mc !== 1'b1) begin
      errors++;
      $display("FAIL wait_state de=%b mc=%b, want 0 1", a_de, a_mc);
    end
    @(negedge clk);
    a_done = 1'b0;
    #1;
    checks++;
    if (a_de !== 1'b1 || a_dv !== 8'hFF || a_mc !== 1'b0 || a_tmo !== 1'b0) begin
      errors++;
      $display("FAIL result de=%b dv=%h mc=%b tmo=%b, want 1 ff 0 0", a_de, a_dv, a_mc, a_tmo);
    end
  endtask
  task automatic test_ignore;
    @(negedge clk);
    a_rdy  = 1'b1;
    a_val  = 8'h33;
    a_done = 1'b1;
    a_res  = 8'h55;
    #1;
    checks++;
    if (a_wr !== 1'b0) begin
      errors++;
      $display("FAIL display_ignore_wr wr=%b, want 0", a_wr);
    end
    @(negedge clk);
    a_rdy  = 1'b0;
    a_done = 1'b0;
    #1;
    checks++;
    if (a_de !== 1'b1 || a_dv !== 8'hFF) begin
      errors++;
      $display("FAIL display_hold de=%b dv=%h, want 1 ff", a_de, a_dv);
    end
    @(negedge clk);
    a_rs = 1'b1;
    @(negedge clk);
    a_rs = 1'b0;
    #1;
    checks++;
    if (a_ien !== 1'b1 || a_de !== 1'b0 || a_dv !== 8'h00 || a_addr !== 4'd0) begin
      errors++;
      $display("FAIL restart ien=%b de=%b dv=%h addr=%0d, want 1 0 00 0", a_ien, a_de, a_dv, a_addr);
    end
    a_write(8'hA0, 4'd0);
  endtask
  task automatic test_reset_mid;
    a_write(8'hA1, 4'd1);
    a_write(8'hA2, 4'd2);
    @(negedge clk);
    a_rdy  = 1'b0;
    a_rs   = 1'b1;
    a_done = 1'b1;
    #1;
    checks++;
    if (a_ien !== 1'b1 || a_addr !== 4'd3 || a_cs !== 1'b0) begin
      errors++;
      $display("FAIL input_ignore ien=%b addr=%0d cs=%b, want 1 3 0", a_ien, a_addr, a_cs);
    end
    a_rs   = 1'b0;
    a_done = 1'b0;
    a_write(8'hA3, 4'd3);
    a_write(8'hA4, 4'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (a_ien !== 0 || a_wr !== 0 || a_addr !== 0 || a_cs !== 0 || a_mc !== 0 || a_de !== 0) begin
      errors++;
      $display("FAIL reset_mid ien=%b wr=%b addr=%0d cs=%b mc=%b de=%b, want all 0",
               a_ien, a_wr, a_addr, a_cs, a_mc, a_de);
    end
    @(negedge clk);
    rst   = 1'b0;
    a_rdy = 1'b0;
    a_fill();
  endtask
  task automatic test_ops3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b_rdy = 1'b1;
      b_val = 8'(8'h20 + i);
      #1;
      checks++;
      if (b_wr !== 1'b1 || b_addr !== 4'(i) || b_wd !== 8'(8'h20 + i) || b_op !== 2'(i / 4) || b_cs !== 1'b0) begin
        errors++;
        $display("FAIL ops3_write i=%0d wr=%b addr=%0d data=%h op=%0d cs=%b, want 1 %0d %h %0d 0",
                 i, b_wr, b_addr, b_wd, b_op, b_cs, i, 8'(8'h20 + i), i / 4);
      end
    end
    @(negedge clk);
    b_rdy = 1'b0;
    #1;
    checks++;
    if (b_cs !== 1'b1 || b_mc !== 1'b1 || b_ien !== 1'b0 || b_de !== 1'b0 || b_tmo !== 1'b0 || b_dv !== 8'h00) begin
      errors++;
      $display("FAIL ops3_start cs=%b mc=%b ien=%b de=%b tmo=%b dv=%h, want 1 1 0 0 0 00",
               b_cs, b_mc, b_ien, b_de, b_tmo, b_dv);
    end
  endtask
`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int early = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      c_rdy = 1'b1;
      c_val = 8'(i + 1);
    end
    @(negedge clk);
    c_rdy = 1'b0;
    #1;
    checks++;
    if (c_cs !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start cs=%b, want 1", c_cs);
    end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      #1;
      if (c_de !== 1'b0 || c_tmo !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL tmo_early cycles=%0d, want 0", early);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_tmo !== 1'b1 || c_de !== 1'b1 || c_dv !== 8'h00 || c_mc !== 1'b0) begin
      errors++;
      $display("FAIL tmo_expire tmo=%b de=%b dv=%h mc=%b, want 1 1 00 0", c_tmo, c_de, c_dv, c_mc);
    end
    c_rs = 1'b1;
    @(negedge clk);
    c_rs = 1'b0;
    #1;
    checks++;
    if (c_tmo !== 1'b0 || c_ien !== 1'b1 || c_addr !== 1'b0 || c_op !== 1'b0 || c_wr !== 1'b0 || c_wd !== 8'h02) begin
      errors++;
      $display("FAIL tmo_restart tmo=%b ien=%b addr=%0d op=%0d wr=%b wd=%h, want 0 1 0 0 0 02",
               c_tmo, c_ien, c_addr, c_op, c_wr, c_wd);
    end
  endtask
`endif
  initial begin
    test_reset();
    a_fill();
    test_result();
    test_ignore();
    test_reset_mid();
    test_ops3();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
